gba_line_stream: RTL and testbench

Downstream consumer of the GPU pixel output port. Collects the colour-shaded RGB pixel writes (`pixel_out_x/y/data/we`) into a double-buffered line store and re-emits each completed line as an in-order ready/valid pixel stream with start/end-of-line markers. This decouples the GPU's bursty pixel timing from the video scaler or HDMI scanner. Lives in the `fclk` domain next to the GPU top.

---
 rtl/gba_line_stream_pkg.sv | 15 +
 rtl/gba_line_stream_if.sv | 33 +++
 rtl/gba_line_stream_ram.sv | 33 +++
 rtl/gba_line_stream.sv | 182 ++++++++++++++++++
 tb/tb_gba_line_stream.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gba_line_stream_pkg.sv
// Shared constants, pixel type and read-FSM states for the GPU line streamer.
package gba_line_stream_pkg;

  localparam int LINE_W = 240;
  localparam int PIX_W  = 18;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/gba_line_stream_if.sv
// Pixel-write input, ready/valid line stream and drop status between the GPU side and the streamer.
interface gba_line_stream_if #(
  parameter int PIX_W = gba_line_stream_pkg::PIX_W
);

  logic [7:0]       pixel_in_x;
  logic [7:0]       pixel_in_y;
  logic [PIX_W-1:0] pixel_in_data;
  logic             pixel_in_we;

  logic [PIX_W-1:0] out_data;
  logic [7:0]       out_x;
  logic [7:0]       out_y;
  logic             out_sol;
  logic             out_eol;
  logic             out_valid;
  logic             out_ready;

  logic             overflow;
  logic [7:0]       drop_count;
  logic             clear_status;

  modport master (
    output pixel_in_x, pixel_in_y, pixel_in_data, pixel_in_we, out_ready, clear_status,
    input  out_data, out_x, out_y, out_sol, out_eol, out_valid, overflow, drop_count
  );

  modport slave (
    input  pixel_in_x, pixel_in_y, pixel_in_data, pixel_in_we, out_ready, clear_status,
    output out_data, out_x, out_y, out_sol, out_eol, out_valid, overflow, drop_count
  );

endinterface

// File: rtl/gba_line_stream_ram.sv
// Two-bank line store: simple dual-port RAM, bank bit selects the upper or lower LINE_W words.
// Synchronous read with one cycle of latency; no reset so it maps onto a single block RAM.
module gba_line_stream_ram #(
  parameter int LINE_W = 240,
  parameter int PIX_W  = 18
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [7:0]       wr_x,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [7:0]       rd_x,
  output logic [PIX_W-1:0] rd_data
);

  localparam int DEPTH = 2 * LINE_W;
  localparam int AW    = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  assign wr_addr = wr_bank ? AW'(LINE_W) + AW'(wr_x) : AW'(wr_x);
  assign rd_addr = rd_bank ? AW'(LINE_W) + AW'(rd_x) : AW'(rd_x);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gba_line_stream.sv
// Collects GPU pixel writes into a double-buffered line store and replays each completed line
// as an in-order ready/valid stream with start/end-of-line tags; drops writes to a full bank.
module gba_line_stream #(
  parameter int LINE_W = gba_line_stream_pkg::LINE_W,
  parameter int PIX_W  = gba_line_stream_pkg::PIX_W
) (
  input logic              fclk,
  input logic              reset,
  gba_line_stream_if.slave bus
);

  import gba_line_stream_pkg::*;

  localparam logic [7:0] LAST_X = 8'(LINE_W - 1);

  logic             wb;
  logic [1:0]       full;
  logic [7:0]       line_y [2];
  logic             in_range;
  logic             wr_blocked;
  logic             wr_ok;
  logic             wr_drop;
  logic             wr_last;

  state_t           state;
  state_t           state_nxt;
  logic             rb;
  logic [7:0]       rx;
  logic             room;
  logic             issue;
  logic             pop;
  logic             drain_clr;
  logic [PIX_W-1:0] ram_rdata;
  logic             pend;
  logic [7:0]       pend_x;
  logic [7:0]       pend_y;

  logic [PIX_W-1:0] q_data [2];
  logic [7:0]       q_x [2];
  logic [7:0]       q_y [2];
  logic             q_wp;
  logic             q_rp;
  logic [1:0]       q_cnt;

  logic             overflow_r;
  logic [7:0]       drop_cnt;

  // A bank being released this cycle already counts as free for an incoming write.
  always_comb begin
    in_range   = int'(bus.pixel_in_x) < LINE_W;
    wr_blocked = full[wb] && !(drain_clr && (rb == wb));
    wr_ok      = bus.pixel_in_we && in_range && !wr_blocked;
    wr_drop    = bus.pixel_in_we && in_range && wr_blocked;
    wr_last    = wr_ok && (bus.pixel_in_x == LAST_X);
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      wb        <= 1'b0;
      full      <= 2'b00;
      line_y[0] <= 8'd0;
      line_y[1] <= 8'd0;
    end else begin
      if (drain_clr) full[rb] <= 1'b0;
      if (wr_last) begin
        full[wb]   <= 1'b1;
        line_y[wb] <= bus.pixel_in_y;
        wb         <= ~wb;
      end
    end
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
      drop_cnt   <= 8'd0;
    end else if (bus.clear_status) begin
      overflow_r <= 1'b0;
      drop_cnt   <= 8'd0;
    end else if (wr_drop) begin
      overflow_r <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  gba_line_stream_ram #(
    .LINE_W (LINE_W),
    .PIX_W  (PIX_W)
  ) u_ram (
    .clk     (fclk),
    .wr_en   (wr_ok),
    .wr_bank (wb),
    .wr_x    (bus.pixel_in_x),
    .wr_data (bus.pixel_in_data),
    .rd_en   (issue),
    .rd_bank (rb),
    .rd_x    (rx),
    .rd_data (ram_rdata)
  );

  // Room test counts the read still in flight: occupancy after it lands must not exceed two.
  always_comb begin
    pop       = (q_cnt != 2'd0) && bus.out_ready;
    room      = ({1'b0, q_cnt} + {2'b00, pend}) <= ({2'b00, pop} + 3'd1);
    drain_clr = (state == DRAIN) && pop && (q_x[q_rp] == LAST_X);
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      // rx is already 0 here, so the first address goes out in the same cycle full is seen.
      IDLE: begin
        if (full[rb] && room) begin
          issue     = 1'b1;
          state_nxt = (rx == LAST_X) ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (room) begin
          issue = 1'b1;
          if (rx == LAST_X) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rb     <= 1'b0;
      rx     <= 8'd0;
      pend   <= 1'b0;
      pend_x <= 8'd0;
      pend_y <= 8'd0;
    end else begin
      state <= state_nxt;
      pend  <= issue;
      if (issue) begin
        pend_x <= rx;
        pend_y <= line_y[rb];
        rx     <= (rx == LAST_X) ? 8'd0 : rx + 8'd1;
      end
      if (drain_clr) rb <= ~rb;
    end
  end

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      q_wp  <= 1'b0;
      q_rp  <= 1'b0;
      q_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_x[i]    <= 8'd0;
        q_y[i]    <= 8'd0;
      end
    end else begin
      if (pend) begin
        q_data[q_wp] <= ram_rdata;
        q_x[q_wp]    <= pend_x;
        q_y[q_wp]    <= pend_y;
        q_wp         <= ~q_wp;
      end
      if (pop) q_rp <= ~q_rp;
      q_cnt <= q_cnt + {1'b0, pend} - {1'b0, pop};
    end
  end

  always_comb begin
    bus.out_valid  = (q_cnt != 2'd0);
    bus.out_data   = q_data[q_rp];
    bus.out_x      = q_x[q_rp];
    bus.out_y      = q_y[q_rp];
    bus.out_sol    = bus.out_valid && (q_x[q_rp] == 8'd0);
    bus.out_eol    = bus.out_valid && (q_x[q_rp] == LAST_X);
    bus.overflow   = overflow_r;
    bus.drop_count = drop_cnt;
  end

endmodule

// File: tb/tb_gba_line_stream.sv
// Randomized bench for gba_line_stream against a line-queue reference model.
module tb_gba_line_stream;

  import gba_line_stream_pkg::*;

  typedef struct {
    pixel_t data;
    int     x;
    int     y;
  } beat_t;

  logic fclk;
  logic reset;
  gba_line_stream_if #(.PIX_W(PIX_W)) bus ();

  gba_line_stream dut (
    .fclk  (fclk),
    .reset (reset),
    .bus   (bus)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int     n_checks = 0;
  int     n_errs   = 0;
  int     cyc      = 0;
  int     rdy_mode = 0;
  bit     lat_arm  = 0;
  bit     span_arm = 0;

  beat_t  exp_q [$];
  pixel_t cur [LINE_W];
  int     pending    = 0;
  int     m_drops    = 0;
  bit     m_ovf      = 0;
  int     wr_cyc     = 0;
  int     sol_cyc    = 0;
  int     beats_seen = 0;

  bit     prev_stall = 0;
  pixel_t p_data;
  int     p_x, p_y;
  bit     p_sol, p_eol;

  always @(posedge fclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: lines become pending when their last pixel lands, are released when
  // their final beat transfers, and writes are dropped only while two lines are pending.
  always @(negedge fclk) begin
    beat_t b;
    if (reset) begin
      exp_q.delete();
      pending    = 0;
      m_drops    = 0;
      m_ovf      = 0;
      prev_stall = 0;
    end else begin
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("drop_count", 32'(bus.drop_count), 32'(m_drops));
      if (prev_stall) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_data", 32'(bus.out_data), 32'(p_data));
        check("stall_x", 32'(bus.out_x), 32'(p_x));
        check("stall_y", 32'(bus.out_y), 32'(p_y));
        check("stall_sol", 32'(bus.out_sol), 32'(p_sol));
        check("stall_eol", 32'(bus.out_eol), 32'(p_eol));
      end
      if (lat_arm && bus.out_valid) begin
        check("first_beat_latency", 32'(cyc - wr_cyc), 32'd3);
        lat_arm = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        beats_seen++;
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("beat_data", 32'(bus.out_data), 32'(b.data));
          check("beat_x", 32'(bus.out_x), 32'(b.x));
          check("beat_y", 32'(bus.out_y), 32'(b.y));
          check("beat_sol", 32'(bus.out_sol), 32'(b.x == 0));
          check("beat_eol", 32'(bus.out_eol), 32'(b.x == LINE_W - 1));
          if (b.x == 0) sol_cyc = cyc;
          if (b.x == LINE_W - 1) begin
            pending--;
            if (span_arm) check("line_no_bubbles", 32'(cyc - sol_cyc), 32'(LINE_W - 1));
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      p_data = bus.out_data;
      p_x    = int'(bus.out_x);
      p_y    = int'(bus.out_y);
      p_sol  = bus.out_sol;
      p_eol  = bus.out_eol;
      if (bus.pixel_in_we && int'(bus.pixel_in_x) < LINE_W) begin
        if (pending == 2) begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end else begin
          cur[bus.pixel_in_x] = bus.pixel_in_data;
          if (int'(bus.pixel_in_x) == LINE_W - 1) begin
            for (int x = 0; x < LINE_W; x++) exp_q.push_back('{cur[x], x, int'(bus.pixel_in_y)});
            pending++;
            wr_cyc = cyc;
          end
        end
      end
      if (bus.clear_status) begin
        m_drops = 0;
        m_ovf   = 0;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge fclk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic put_pix(input int x, input int y, input pixel_t d);
    @(posedge fclk);
    #1;
    bus.pixel_in_we   = 1'b1;
    bus.pixel_in_x    = 8'(x);
    bus.pixel_in_y    = 8'(y);
    bus.pixel_in_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge fclk);
      #1;
      bus.pixel_in_we = 1'b0;
    end
  endtask

  task automatic write_line(input int y, input int first, input int last, input bit rnd, input bit gaps);
    for (int x = first; x <= last; x++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      put_pix(x, y, rnd ? pixel_t'($urandom) : pixel_t'(x));
    end
    idle(1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge fclk);
      if (exp_q.size() == 0) break;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge fclk);
    #1;
    check("valid_after_drain", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_sol"}, 32'(bus.out_sol), 32'd0);
    check({tag, "_eol"}, 32'(bus.out_eol), 32'd0);
    check({tag, "_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_x"}, 32'(bus.out_x), 32'd0);
    check({tag, "_y"}, 32'(bus.out_y), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, "_drops"}, 32'(bus.drop_count), 32'd0);
  endtask

  initial begin
    int base;
    reset             = 1'b1;
    bus.pixel_in_we   = 1'b0;
    bus.pixel_in_x    = 8'd0;
    bus.pixel_in_y    = 8'd0;
    bus.pixel_in_data = '0;
    bus.clear_status  = 1'b0;
    repeat (3) @(posedge fclk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(3);

    // Single line, ready held high: latency and gap-free streaming.
    rdy_mode = 1;
    lat_arm  = 1;
    span_arm = 1;
    write_line(5, 0, LINE_W - 1, 0, 0);
    wait_drain(1000);
    span_arm = 0;
    check("latency_seen", 32'(lat_arm), 32'd0);

    // Both banks full, a third line is dropped; release while rewriting x=0.
    rdy_mode = 0;
    write_line(1, 0, LINE_W - 1, 1, 0);
    write_line(2, 0, LINE_W - 1, 1, 0);
    write_line(9, 0, LINE_W - 1, 1, 0);
    check("ovf_after_third", 32'(bus.overflow), 32'd1);
    check("drops_after_third", 32'(bus.drop_count), 32'd240);
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) put_pix(0, 3, pixel_t'($urandom));
    write_line(3, 1, LINE_W - 1, 1, 0);
    wait_drain(2000);
    bus.clear_status = 1'b1;
    idle(1);
    bus.clear_status = 1'b0;

    // Random backpressure and random write gaps, two lines overlapping.
    rdy_mode = 2;
    write_line(40, 0, LINE_W - 1, 1, 1);
    write_line(41, 0, LINE_W - 1, 1, 1);
    wait_drain(4000);

    // Partial line restarted in place.
    rdy_mode = 1;
    write_line(7, 0, 99, 1, 0);
    write_line(7, 0, LINE_W - 1, 1, 0);
    wait_drain(1000);
    check("restart_no_ovf", 32'(bus.overflow), 32'd0);

    // Reset in the middle of a stream.
    base = beats_seen;
    write_line(20, 0, LINE_W - 1, 1, 0);
    for (int i = 0; i < 1000; i++) begin
      if (beats_seen - base >= 120) break;
      @(posedge fclk);
    end
    check("reached_beat_120", 32'(beats_seen - base >= 120), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(posedge fclk);
    #1;
    reset = 1'b0;
    idle(2);
    write_line(21, 0, LINE_W - 1, 1, 0);
    wait_drain(1000);

    // Saturating drop counter, then a clear that coincides with a drop.
    rdy_mode = 0;
    write_line(10, 0, LINE_W - 1, 1, 0);
    write_line(11, 0, LINE_W - 1, 1, 0);
    write_line(12, 0, LINE_W - 1, 1, 0);
    write_line(12, 0, 59, 1, 0);
    check("drops_saturated", 32'(bus.drop_count), 32'd255);
    check("ovf_saturated", 32'(bus.overflow), 32'd1);
    put_pix(5, 12, pixel_t'($urandom));
    bus.clear_status = 1'b1;
    idle(1);
    bus.clear_status = 1'b0;
    check("drops_cleared", 32'(bus.drop_count), 32'd0);
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    rdy_mode = 1;
    wait_drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
